emesh_mem_target: RTL and testbench

EMESH_MEM_TARGET -- requirements
Module: emesh_mem_target

---
 rtl/emesh_mem_target.sv | 151 +++++++++++++++
 tb/tb_emesh_mem_target.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emesh_mem_target.sv
// emesh_mem_target: single-port word memory behind an emesh write/read
// request pair, with a one-entry registered read-response slot.
//
// Ports:
//   s_axi_aclk    : clock, all state updates on rising edge
//   s_axi_aresetn : asynchronous active-low reset
//   wr_access     : write request valid
//   wr_packet     : write request packet (104 bits)
//   wr_wait       : backpressure to write source
//   rd_access     : read request valid
//   rd_packet     : read request packet (104 bits)
//   rd_wait       : backpressure to read source
//   rr_access     : read response valid
//   rr_packet     : read response packet (104 bits)
//   rr_wait       : backpressure from response sink
//
// Packet layout: [0] write, [2:1] datamode, [7:3] ctrlmode,
//   [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
module emesh_mem_target #(
    parameter int AW = 6
) (
    input  logic         s_axi_aclk,
    input  logic         s_axi_aresetn,
    input  logic         wr_access,
    input  logic [103:0] wr_packet,
    output logic         wr_wait,
    input  logic         rd_access,
    input  logic [103:0] rd_packet,
    output logic         rd_wait,
    output logic         rr_access,
    output logic [103:0] rr_packet,
    input  logic         rr_wait
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    logic        resp_full;
    logic        last_rd;
    logic        rd_ok;
    logic        conflict;
    logic        grant_rd;
    logic        grant_wr;

    logic [1:0]  w_mode;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;

    logic [1:0]  r_mode;
    logic [31:0] r_addr;
    logic [31:0] r_word;
    logic [31:0] r_byte_sh;
    logic [31:0] r_half_sh;
    logic [31:0] r_data;

    logic        unused_bits;

    assign rr_access = resp_full;

    // The response slot can take a new read if it is empty or is
    // being drained this very cycle.
    assign rd_ok    = s_axi_aresetn & (~resp_full | ~rr_wait);
    assign conflict = wr_access & rd_access & rd_ok;

    // On conflict the read wins only when the write won last time.
    assign grant_rd = rd_access & rd_ok & (~wr_access | ~last_rd);
    assign grant_wr = s_axi_aresetn & wr_access & ~grant_rd;

    assign wr_wait = ~s_axi_aresetn | (wr_access & grant_rd);
    assign rd_wait = ~s_axi_aresetn | (rd_access & ~grant_rd);

    assign w_mode = wr_packet[2:1];
    assign w_addr = wr_packet[39:8];
    assign w_data = wr_packet[71:40];

    // Low-order data is replicated into every lane; the byte enables
    // pick the lane that matches the address.
    always_comb begin
        w_be    = 4'b1111;
        w_lanes = w_data;
        unique case (w_mode)
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_lanes = {4{w_data[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = w_data;
            end
        endcase
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge s_axi_aclk) begin
        if (grant_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem[w_addr[AW+1:2]][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
    end

    assign r_mode    = rd_packet[2:1];
    assign r_addr    = rd_packet[39:8];
    assign r_word    = mem[r_addr[AW+1:2]];
    assign r_byte_sh = r_word >> {r_addr[1:0], 3'b000};
    assign r_half_sh = r_word >> {r_addr[1], 4'b0000};

    always_comb begin
        r_data = r_word;
        unique case (r_mode)
            2'b00:   r_data = {24'h0, r_byte_sh[7:0]};
            2'b01:   r_data = {16'h0, r_half_sh[15:0]};
            default: r_data = r_word;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            resp_full <= 1'b0;
            rr_packet <= '0;
            last_rd   <= 1'b1;
        end else begin
            if (conflict) begin
                last_rd <= ~last_rd;
            end
            if (grant_rd) begin
                resp_full <= 1'b1;
                rr_packet <= {32'h0, r_data, rd_packet[103:72],
                              rd_packet[7:3], rd_packet[2:1], 1'b1};
            end else if (!rr_wait) begin
                resp_full <= 1'b0;
            end
        end
    end

    // Fields that the target deliberately does not look at.
    assign unused_bits = ^{wr_packet[103:72], wr_packet[39:AW+10],
                           wr_packet[7:3], wr_packet[0],
                           rd_packet[71:40], rd_packet[39:AW+10],
                           rd_packet[0]};

endmodule

// File: tb/tb_emesh_mem_target.sv
// tb_emesh_mem_target: directed and randomized checks of emesh_mem_target
// against a byte-array memory and transaction-level arbitration model.
module tb_emesh_mem_target;

    localparam int AW = 6;
    localparam int NB = 4 << AW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_access;
    logic [103:0] wr_packet;
    logic         wr_wait;
    logic         rd_access;
    logic [103:0] rd_packet;
    logic         rd_wait;
    logic         rr_access;
    logic [103:0] rr_packet;
    logic         rr_wait;

    int checks = 0;
    int errors = 0;

    logic [7:0]   mb [NB];
    bit           m_full;
    logic [103:0] m_pkt;
    bit           m_last_rd;
    bit           g_rd;
    bit           g_wr;
    bit           e_ww;
    bit           e_rw;

    always #5 clk = ~clk;

    emesh_mem_target #(.AW(AW)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .wr_access     (wr_access),
        .wr_packet     (wr_packet),
        .wr_wait       (wr_wait),
        .rd_access     (rd_access),
        .rd_packet     (rd_packet),
        .rd_wait       (rd_wait),
        .rr_access     (rr_access),
        .rr_packet     (rr_packet),
        .rr_wait       (rr_wait)
    );

    function automatic logic [103:0] pkt(input bit w, input logic [1:0] dm,
                                         input logic [4:0] cm,
                                         input logic [31:0] dst,
                                         input logic [31:0] data,
                                         input logic [31:0] src);
        return {src, data, dst, cm, dm, w};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a,
                                             input logic [1:0] dm);
        int base;
        int h;
        int w;
        base = int'(a % NB);
        h = base & ~1;
        w = base & ~3;
        if (dm == 2'b00) return {24'h0, mb[base]};
        if (dm == 2'b01) return {16'h0, mb[h+1], mb[h]};
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [1:0] dm,
                             input logic [31:0] d);
        int base;
        int h;
        int w;
        base = int'(a % NB);
        h = base & ~1;
        w = base & ~3;
        if (dm == 2'b00) begin
            mb[base] = d[7:0];
        end else if (dm == 2'b01) begin
            mb[h]   = d[7:0];
            mb[h+1] = d[15:8];
        end else begin
            mb[w]   = d[7:0];
            mb[w+1] = d[15:8];
            mb[w+2] = d[23:16];
            mb[w+3] = d[31:24];
        end
    endtask

    task automatic chk(input string tag, input logic [103:0] got,
                       input logic [103:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a falling edge with inputs already driven; returns at
    // the next falling edge after the model has absorbed the cycle.
    task automatic tick();
        bit elig;
        bit conf;
        #1;
        elig = !m_full || !rr_wait;
        conf = wr_access && rd_access && elig;
        g_rd = 1'b0;
        g_wr = 1'b0;
        if (conf) begin
            if (m_last_rd) g_wr = 1'b1;
            else g_rd = 1'b1;
        end else if (rd_access && elig) begin
            g_rd = 1'b1;
        end else if (wr_access) begin
            g_wr = 1'b1;
        end
        chk("wr_wait", wr_wait, wr_access && g_rd);
        chk("rd_wait", rd_wait, rd_access && !g_rd);
        @(posedge clk);
        #1;
        if (conf) m_last_rd = !m_last_rd;
        if (g_wr) ref_write(wr_packet[39:8], wr_packet[2:1], wr_packet[71:40]);
        if (g_rd) begin
            m_full = 1'b1;
            m_pkt = pkt(1'b1, rd_packet[2:1], rd_packet[7:3], rd_packet[103:72],
                        ref_read(rd_packet[39:8], rd_packet[2:1]), 32'h0);
        end else if (!rr_wait) begin
            m_full = 1'b0;
        end
        chk("rr_access", rr_access, m_full);
        if (m_full) chk("rr_packet", rr_packet, m_pkt);
        e_ww = wr_access && g_rd;
        e_rw = rd_access && !g_rd;
        @(negedge clk);
    endtask

    task automatic idle();
        wr_access = 1'b0;
        rd_access = 1'b0;
        rr_wait   = 1'b0;
    endtask

    task automatic model_reset();
        m_full    = 1'b0;
        m_last_rd = 1'b1;
        e_ww      = 1'b0;
        e_rw      = 1'b0;
    endtask

    initial begin
        logic [103:0] held;

        rst_n     = 1'b0;
        wr_access = 1'b1;
        wr_packet = pkt(1'b1, 2'b10, 5'h0, 32'h10, 32'h55555555, 32'h0);
        rd_access = 1'b1;
        rd_packet = pkt(1'b0, 2'b10, 5'h0, 32'h10, 32'h0, 32'h1);
        rr_wait   = 1'b0;
        model_reset();
        for (int i = 0; i < NB; i++) mb[i] = 8'h00;

        #12;
        chk("rst_wr_wait", wr_wait, 1'b1);
        chk("rst_rd_wait", rd_wait, 1'b1);
        chk("rst_rr_access", rr_access, 1'b0);
        chk("rst_rr_packet", rr_packet, 104'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous requests right after reset: W, R, W, R.
        wr_packet = pkt(1'b1, 2'b10, 5'h0, 32'h10, 32'hDEADBEEF, 32'h0);
        rd_packet = pkt(1'b0, 2'b10, 5'h3, 32'h10, 32'h0, 32'h80000000);
        tick();
        chk("c1_rr_access", rr_access, 1'b0);
        wr_packet = pkt(1'b1, 2'b10, 5'h0, 32'h20, 32'hCAFEF00D, 32'h0);
        tick();
        chk("c2_rr_access", rr_access, 1'b1);
        chk("c2_data", rr_packet[71:40], 32'hDEADBEEF);
        chk("c2_dst", rr_packet[39:8], 32'h80000000);
        chk("c2_write", rr_packet[0], 1'b1);
        chk("c2_src", rr_packet[103:72], 32'h0);
        rd_packet = pkt(1'b0, 2'b10, 5'h0, 32'h20, 32'h0, 32'h1234);
        tick();
        chk("c3_rr_access", rr_access, 1'b0);
        wr_packet = pkt(1'b1, 2'b10, 5'h0, 32'h30, 32'h0, 32'h0);
        tick();
        chk("c4_data", rr_packet[71:40], 32'hCAFEF00D);
        idle();
        tick();

        // Fill the whole memory through aliased addresses.
        for (int i = 0; i < (1 << AW); i++) begin
            wr_access = 1'b1;
            wr_packet = pkt(1'b1, 2'b10, 5'h0,
                            {$urandom_range(0, 255), 24'h0} | (i * 4),
                            $urandom, $urandom);
            tick();
        end
        idle();

        // Byte write into a known word, then word and byte reads.
        wr_access = 1'b1;
        wr_packet = pkt(1'b1, 2'b10, 5'h0, 32'h10, 32'h11223344, 32'h0);
        tick();
        wr_packet = pkt(1'b1, 2'b00, 5'h0, 32'h13, 32'h5A5A5AAB, 32'h0);
        tick();
        wr_access = 1'b0;
        rd_access = 1'b1;
        rd_packet = pkt(1'b0, 2'b10, 5'h0, 32'h10, 32'h0, 32'h44);
        tick();
        chk("byte_word_rd", rr_packet[71:40], 32'hAB223344);
        rd_packet = pkt(1'b0, 2'b00, 5'h1F, 32'h13, 32'h0, 32'h48);
        tick();
        chk("byte_rd", rr_packet[71:40], 32'h000000AB);
        chk("byte_rd_ctrl", rr_packet[7:3], 5'h1F);

        // Response stall: second read must wait until the sink drains.
        rd_packet = pkt(1'b0, 2'b10, 5'h0, 32'h10, 32'h0, 32'h50);
        tick();
        held = rr_packet;
        rr_wait = 1'b1;
        rd_packet = pkt(1'b0, 2'b00, 5'h0, 32'h13, 32'h0, 32'h54);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_stable", rr_packet, held);
        end
        rr_wait = 1'b0;
        tick();
        chk("stall_release", rr_packet[71:40], 32'h000000AB);
        chk("stall_release_dst", rr_packet[39:8], 32'h54);

        // Back-to-back reads, no bubbles.
        for (int i = 0; i < 8; i++) begin
            rd_packet = pkt(1'b0, 2'($urandom_range(0, 3)), 5'h0,
                            $urandom, 32'h0, $urandom);
            tick();
            chk("b2b_valid", rr_access, 1'b1);
        end
        idle();
        tick();

        // Random traffic with hold-while-waiting sources.
        for (int i = 0; i < 400; i++) begin
            if (!(wr_access && e_ww)) begin
                wr_access = ($urandom_range(0, 2) != 0);
                wr_packet = pkt(1'($urandom_range(0, 1)),
                                2'($urandom_range(0, 3)),
                                5'($urandom_range(0, 31)),
                                $urandom, $urandom, $urandom);
            end
            if (!(rd_access && e_rw)) begin
                rd_access = ($urandom_range(0, 2) != 0);
                rd_packet = pkt(1'($urandom_range(0, 1)),
                                2'($urandom_range(0, 3)),
                                5'($urandom_range(0, 31)),
                                $urandom, $urandom, $urandom);
            end
            rr_wait = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle();
        tick();

        // Reset while a response is pending.
        wr_access = 1'b1;
        wr_packet = pkt(1'b1, 2'b10, 5'h0, 32'h10, 32'h0BADCAFE, 32'h0);
        tick();
        wr_access = 1'b0;
        rd_access = 1'b1;
        rd_packet = pkt(1'b0, 2'b10, 5'h0, 32'h20, 32'h0, 32'h60);
        rr_wait = 1'b1;
        tick();
        chk("pre_rst_valid", rr_access, 1'b1);
        wr_access = 1'b1;
        wr_packet = pkt(1'b1, 2'b10, 5'h0, 32'h10, 32'h99999999, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rr_access", rr_access, 1'b0);
        chk("async_rr_packet", rr_packet, 104'h0);
        chk("async_wr_wait", wr_wait, 1'b1);
        chk("async_rd_wait", rd_wait, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        wr_access = 1'b0;
        rr_wait = 1'b0;
        #1;
        chk("post_rst_valid", rr_access, 1'b0);
        rd_packet = pkt(1'b0, 2'b10, 5'h0, 32'h10, 32'h0, 32'h70);
        #1;
        tick();
        chk("post_rst_data", rr_packet[71:40], 32'h0BADCAFE);
        chk("post_rst_dst", rr_packet[39:8], 32'h70);
        idle();
        tick();
        chk("post_rst_drain", rr_access, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
